// File: rtl/cond_pkg.sv
// Shared condition-code and flag definitions for the condition evaluation unit.
package cond_pkg;

  localparam int unsigned COND_LEN = 4;

  localparam logic [COND_LEN-1:0] COND_EQ = 4'b0000;
  localparam logic [COND_LEN-1:0] COND_NE = 4'b0001;
  localparam logic [COND_LEN-1:0] COND_CS = 4'b0010;
  localparam logic [COND_LEN-1:0] COND_CC = 4'b0011;
  localparam logic [COND_LEN-1:0] COND_MI = 4'b0100;
  localparam logic [COND_LEN-1:0] COND_PL = 4'b0101;
  localparam logic [COND_LEN-1:0] COND_VS = 4'b0110;
  localparam logic [COND_LEN-1:0] COND_VC = 4'b0111;
  localparam logic [COND_LEN-1:0] COND_HI = 4'b1000;
  localparam logic [COND_LEN-1:0] COND_LS = 4'b1001;
  localparam logic [COND_LEN-1:0] COND_GE = 4'b1010;
  localparam logic [COND_LEN-1:0] COND_LT = 4'b1011;
  localparam logic [COND_LEN-1:0] COND_GT = 4'b1100;
  localparam logic [COND_LEN-1:0] COND_LE = 4'b1101;
  localparam logic [COND_LEN-1:0] COND_AL = 4'b1110;
  localparam logic [COND_LEN-1:0] COND_NV = 4'b1111;

  // Bit positions within the {N,Z,C,V} flag nibble.
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/cond_decode.sv
// Combinational ARM-style condition check of one code against a flag nibble.
module cond_decode
  import cond_pkg::*;
(
  input  logic [COND_LEN-1:0] cond,
  input  logic [3:0]          flags,
  output logic                pass
);

  logic n, z, c, v;

  always_comb begin
    n    = flags[FLAG_N];
    z    = flags[FLAG_Z];
    c    = flags[FLAG_C];
    v    = flags[FLAG_V];
    pass = 1'b0;
    unique case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_eval_unit.sv
// Multi-lane condition evaluator: status register, 1-cycle result pipeline with
// stall/flush, and per-lane saturating failed-condition counters.
module cond_eval_unit
  import cond_pkg::*;
#(
  parameter int unsigned LANES  = 2,
  parameter int unsigned BYPASS = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         status_we,
  input  logic [3:0]                   status_in,
  input  logic                         stall,
  input  logic                         flush,
  input  logic [LANES-1:0]             in_valid,
  input  logic [LANES*COND_LEN-1:0]    in_cond,
  output logic [LANES-1:0]             out_valid,
  output logic [LANES-1:0]             out_pass,
  output logic [3:0]                   status_out,
  output logic [LANES*CNT_W-1:0]       fail_cnt
);

  logic [3:0]                  status_d, status_q;
  logic [3:0]                  eval_flags;
  logic [LANES-1:0]            lane_pass;
  logic [LANES-1:0]            valid_d, valid_q;
  logic [LANES-1:0]            pass_d, pass_q;
  logic [LANES-1:0][CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    status_d   = status_we ? status_in : status_q;
    eval_flags = ((BYPASS != 0) && status_we) ? status_in : status_q;
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    cond_decode u_cond_decode (
      .cond  (in_cond[COND_LEN*i +: COND_LEN]),
      .flags (eval_flags),
      .pass  (lane_pass[i])
    );
  end

  always_comb begin
    valid_d = valid_q;
    pass_d  = pass_q;
    cnt_d   = cnt_q;
    if (flush) begin
      valid_d = '0;
    end else if (!stall) begin
      valid_d = in_valid;
      pass_d  = lane_pass;
      for (int i = 0; i < LANES; i++) begin
        if (in_valid[i] && !lane_pass[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q <= '0;
      valid_q  <= '0;
      pass_q   <= '0;
      cnt_q    <= '0;
    end else begin
      status_q <= status_d;
      valid_q  <= valid_d;
      pass_q   <= pass_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_pass   = pass_q;
  assign status_out = status_q;
  assign fail_cnt   = cnt_q;

endmodule

// File: tb/tb_cond_eval_unit.sv
// Directed bench for cond_eval_unit: default, no-bypass and 4-bit-counter builds
// share one stimulus stream.
module tb_cond_eval_unit;

  logic       clk;
  logic       rst_n;
  logic       status_we;
  logic [3:0] status_in;
  logic       stall;
  logic       flush;
  logic [1:0] in_valid;
  logic [7:0] in_cond;

  logic [1:0]  ov_a, op_a, ov_b, op_b, ov_c, op_c;
  logic [3:0]  st_a, st_b, st_c;
  logic [31:0] fc_a, fc_b;
  logic [7:0]  fc_c;

  int checks = 0;
  int errors = 0;

  cond_eval_unit #(.LANES(2), .BYPASS(1), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .status_we(status_we), .status_in(status_in),
    .stall(stall), .flush(flush), .in_valid(in_valid), .in_cond(in_cond),
    .out_valid(ov_a), .out_pass(op_a), .status_out(st_a), .fail_cnt(fc_a)
  );

  cond_eval_unit #(.LANES(2), .BYPASS(0), .CNT_W(16)) dut_nb (
    .clk(clk), .rst_n(rst_n), .status_we(status_we), .status_in(status_in),
    .stall(stall), .flush(flush), .in_valid(in_valid), .in_cond(in_cond),
    .out_valid(ov_b), .out_pass(op_b), .status_out(st_b), .fail_cnt(fc_b)
  );

  cond_eval_unit #(.LANES(2), .BYPASS(1), .CNT_W(4)) dut_c4 (
    .clk(clk), .rst_n(rst_n), .status_we(status_we), .status_in(status_in),
    .stall(stall), .flush(flush), .in_valid(in_valid), .in_cond(in_cond),
    .out_valid(ov_c), .out_pass(op_c), .status_out(st_c), .fail_cnt(fc_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic model(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    check("rst_valid", {30'd0, ov_a}, 32'd0);
    check("rst_pass", {30'd0, op_a}, 32'd0);
    check("rst_status", {28'd0, st_a}, 32'd0);
    check("rst_fail", fc_a, 32'd0);
    check("rst_fail_c4", {24'd0, fc_c}, 32'd0);
    check("rst_valid_c4", {30'd0, ov_c}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] f4, c4, prev;
    int exp0, exp1;
    rst_n = 1'b1; status_we = 1'b0; status_in = 4'd0; stall = 1'b0; flush = 1'b0;
    in_valid = 2'b00; in_cond = 8'd0;
    #1 rst_n = 1'b0;
    #2;
    check("reset_valid", {30'd0, ov_a}, 32'd0);
    check("reset_pass", {30'd0, op_a}, 32'd0);
    check("reset_status", {28'd0, st_a}, 32'd0);
    check("reset_fail", fc_a, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Same-cycle status write forwarded (or not) to EQ on lane 0.
    status_we = 1'b1; status_in = 4'b0100; in_valid = 2'b01; in_cond = 8'h00;
    tick();
    check("byp_valid", {30'd0, ov_a}, 32'd1);
    check("byp_pass", {31'd0, op_a[0]}, 32'd1);
    check("nobyp_pass", {31'd0, op_b[0]}, 32'd0);
    check("nobyp_valid", {30'd0, ov_b}, 32'd1);
    check("byp_status", {28'd0, st_a}, 32'h4);

    // Full code x flag sweep; lane 1 runs the complementary code.
    prev = 4'b0100; exp0 = 0; exp1 = 0;
    for (int f = 0; f < 16; f++) begin
      for (int c = 0; c < 16; c++) begin
        f4 = 4'(f); c4 = 4'(c);
        status_we = 1'b1; status_in = f4; in_valid = 2'b11;
        in_cond = {4'(15 - c), c4};
        tick();
        check("sweep_l0", {31'd0, op_a[0]}, {31'd0, model(c4, f4)});
        check("sweep_l1", {31'd0, op_a[1]}, {31'd0, model(4'(15 - c), f4)});
        check("sweep_nb_l0", {31'd0, op_b[0]}, {31'd0, model(c4, prev)});
        if (!model(c4, f4)) exp0++;
        if (!model(4'(15 - c), f4)) exp1++;
        prev = f4;
      end
    end
    check("sweep_valid", {30'd0, ov_a}, 32'd3);
    check("sweep_fail0", {16'd0, fc_a[15:0]}, 32'(exp0));
    check("sweep_fail1", {16'd0, fc_a[31:16]}, 32'(exp1));
    check("sweep_status", {28'd0, st_a}, 32'hF);

    status_we = 1'b0; in_valid = 2'b00;
    tick();
    check("idle_valid", {30'd0, ov_a}, 32'd0);

    // Accept failing GT on lane 1, then hold under stall with new inputs.
    reset_pulse();
    status_we = 1'b1; status_in = 4'b1000; in_valid = 2'b10; in_cond = 8'hC0;
    tick();
    check("gt_valid", {30'd0, ov_a}, 32'h2);
    check("gt_pass", {30'd0, op_a}, 32'h0);
    check("gt_fail1", {16'd0, fc_a[31:16]}, 32'd1);
    status_we = 1'b0; stall = 1'b1; in_valid = 2'b11; in_cond = 8'hE1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall_valid", {30'd0, ov_a}, 32'h2);
      check("stall_pass", {30'd0, op_a}, 32'h0);
      check("stall_fail1", {16'd0, fc_a[31:16]}, 32'd1);
      check("stall_fail0", {16'd0, fc_a[15:0]}, 32'd0);
    end

    // Flush wins over stall; status write still lands.
    flush = 1'b1; status_we = 1'b1; status_in = 4'b0011;
    tick();
    check("flush_valid", {30'd0, ov_a}, 32'h0);
    check("flush_status", {28'd0, st_a}, 32'h3);
    check("flush_fail1", {16'd0, fc_a[31:16]}, 32'd1);

    // Saturation of the 4-bit counter with NV requests on lane 0.
    stall = 1'b0; flush = 1'b0; status_we = 1'b0; in_valid = 2'b01; in_cond = 8'h0F;
    for (int k = 1; k <= 20; k++) begin
      tick();
      check("sat_c4", {28'd0, fc_c[3:0]}, (k > 15) ? 32'd15 : 32'(k));
    end
    check("sat_wide", {16'd0, fc_a[15:0]}, 32'd20);

    // Reset during stall+flush, then first accepted edge behaves as cycle 0.
    stall = 1'b1; flush = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_fail_c4", {24'd0, fc_c}, 32'd0);
    check("mid_rst_valid", {30'd0, ov_c}, 32'd0);
    check("mid_rst_status", {28'd0, st_c}, 32'd0);
    check("mid_rst_fail", fc_a, 32'd0);
    stall = 1'b0; flush = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_valid", {30'd0, ov_c}, 32'd1);
    check("post_rst_pass", {30'd0, op_c}, 32'd0);
    check("post_rst_fail_c4", {28'd0, fc_c[3:0]}, 32'd1);
    check("post_rst_fail", {16'd0, fc_a[15:0]}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cond_eval_unit.md
COND_EVAL_UNIT -- requirements
Module: cond_eval_unit

Interface
REQ-001 The block SHALL have parameter LANES, default 2, meaning the number of parallel condition-evaluation lanes (legal 1..4).
REQ-002 The block SHALL have parameter BYPASS, default 1, meaning that a same-cycle status write is forwarded to evaluation (1) or not (0).
REQ-003 The block SHALL have parameter CNT_W, default 16, meaning the width of the per-lane failed-condition counter.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock, rising-edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit, the asynchronous active-low reset.
REQ-006 The block SHALL have port status_we, input, 1 bit, the write strobe for the status register (S-bit instruction retiring).
REQ-007 The block SHALL have port status_in, input, 4 bits, the new flags {N,Z,C,V}, bit 3 = N.
REQ-008 The block SHALL have port stall, input, 1 bit, which holds the evaluation pipeline.
REQ-009 The block SHALL have port flush, input, 1 bit, which kills all lane results.
REQ-010 The block SHALL have port in_valid, input, LANES bits, the per-lane request valid.
REQ-011 The block SHALL have port in_cond, input, LANES*4 bits, the per-lane condition code; lane i occupies [4i+3:4i].
REQ-012 The block SHALL have port out_valid, output, LANES bits, the registered per-lane result valid.
REQ-013 The block SHALL have port out_pass, output, LANES bits, the registered per-lane condition result.
REQ-014 The block SHALL have port status_out, output, 4 bits, the current architectural flags.
REQ-015 The block SHALL have port fail_cnt, output, LANES*CNT_W bits, the per-lane saturating count of valid-but-failed evaluations.

Function
REQ-016 The block SHALL hold a 4-bit status register, loaded with status_in on a clk edge when status_we=1, independent of stall and flush.
REQ-017 The eval flags SHALL equal status_in when BYPASS=1 and status_we=1, and SHALL otherwise equal the status register.
REQ-018 Each lane SHALL evaluate against eval flags using the ARM table: EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V, HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V), AL 1, code 4'b1111 (NV) 0.
REQ-019 Latency SHALL be exactly 1 cycle: on the edge after in_valid[i]=1 with stall=0 and flush=0, out_valid[i]=1 and out_pass[i] equals the result.
REQ-020 When stall=1 and flush=0, out_valid and out_pass SHALL hold their values and fail_cnt SHALL not change.
REQ-021 When flush=1, out_valid SHALL clear to 0 on the next edge regardless of stall; out_pass is don't-care.
REQ-022 When stall=0 and flush=0 with in_valid[i]=0, out_valid[i] SHALL be 0 on the next edge.
REQ-023 fail_cnt[i] SHALL increment by 1 on an edge where lane i is accepted (in_valid[i]=1, stall=0, flush=0) and its result is 0, and SHALL saturate at all-ones without wrapping.
REQ-024 All lanes SHALL see identical eval flags in a given cycle; lanes SHALL be independent otherwise.
REQ-025 status_out SHALL reflect the status register (not the bypassed value).

Reset
REQ-026 On rst_n=0, asynchronously, the status register, status_out, out_valid, out_pass and all fail_cnt SHALL become 0.
REQ-027 Reset asserted mid-stall or mid-flush SHALL override both; the first post-reset accepted edge SHALL behave as cycle 0.

Structure
REQ-028 Shared package cond_pkg SHALL hold the COND_* 4-bit codes, COND_LEN=4, and the flag bit indices N=3, Z=2, C=1, V=0.
REQ-029 A combinational sub-module cond_decode (inputs cond, flags; output pass) SHALL be instantiated once per lane; the register, counters and control SHALL live in cond_eval_unit.

Verification
REQ-030 Reset, then status_we=1 with status_in=4'b0100, lane0 cond EQ same cycle, BYPASS=1 -> next cycle out_valid[0]=1, out_pass[0]=1; with BYPASS=0 -> out_pass[0]=0.
REQ-031 All 16 codes x 16 flag values on lane 0 -> out_pass matches REQ-018, including LS with C=1,Z=1 -> 1 and NV -> 0.
REQ-032 Accept lane1 GT with N=1,V=0, then stall=1 for 3 cycles with new inputs -> outputs held, fail_cnt[1]=1 throughout.
REQ-033 stall=1 and flush=1 together -> out_valid=0 next edge; a concurrent status_we=1 still updates status_out.
REQ-034 CNT_W=4, 20 failing accepted requests on lane 0 -> fail_cnt[0]=15, no wrap; rst_n pulse mid-sequence -> all outputs 0 immediately.
